// File: rtl/irq_ctrl_pkg.sv
// Shared constants, types and helpers for the irq_ctrl interrupt controller.
// The optional NMI build (IRQ_CTRL_NMI_EN) is resolved in the top module.
package irq_ctrl_pkg;

  localparam int N_SRC = 8;

  localparam logic [3:0] REG_PEND   = 4'h0;
  localparam logic [3:0] REG_MASK   = 4'h1;
  localparam logic [3:0] REG_MODE   = 4'h2;
  localparam logic [3:0] REG_VECTOR = 4'h3;
  localparam logic [3:0] REG_EOI    = 4'h4;
  localparam logic [3:0] REG_ISR    = 4'h5;

  localparam int VEC_VALID_BIT = 7;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ASSERT = 1'b1
  } irq_state_e;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } cand_t;

  // Lowest set bit of v; bit 0 is the highest priority.
  function automatic cand_t lowest_set(input logic [N_SRC-1:0] v);
    cand_t c;
    c = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (v[i]) begin
        c.found = 1'b1;
        c.idx   = 3'(i);
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// Per-source 2-flop synchronizer plus a delay flop for rising-edge detection.
module irq_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic level_o,
  output logic rise_o
);

  logic meta_q;
  logic sync_q;
  logic dly_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      dly_q  <= 1'b0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      dly_q  <= sync_q;
    end
  end

  assign level_o = sync_q;
  assign rise_o  = sync_q & ~dly_q;

endmodule

// File: rtl/irq_ctrl.sv
// Eight-source prioritized interrupt controller with edge/level modes and nesting.
// Define IRQ_CTRL_NMI_EN to turn src[0] into an unmaskable edge NMI.
module irq_ctrl
  import irq_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       AD,
  input  logic [7:0]       DI,
  output logic [7:0]       DO,
  input  logic             rw,
  input  logic             cs,
  input  logic [N_SRC-1:0] src,
  output logic             irq,
  output logic             nmi,
  output irq_state_e       fsm_state_o
);

`ifdef IRQ_CTRL_NMI_EN
  localparam logic [N_SRC-1:0] NMI_BIT = 8'h01;
`else
  localparam logic [N_SRC-1:0] NMI_BIT = 8'h00;
`endif
  localparam logic [N_SRC-1:0] CFG_BITS = ~NMI_BIT;

  logic [N_SRC-1:0] sync_lvl;
  logic [N_SRC-1:0] sync_rise;

  for (genvar g = 0; g < N_SRC; g++) begin : g_src
    irq_sync_edge u_sync (
      .clk     (clk),
      .rst     (rst),
      .async_i (src[g]),
      .level_o (sync_lvl[g]),
      .rise_o  (sync_rise[g])
    );
  end

  logic [N_SRC-1:0] pend_q, pend_d;
  logic [N_SRC-1:0] mask_q, mask_d;
  logic [N_SRC-1:0] mode_q, mode_d;
  logic [N_SRC-1:0] isr_q, isr_d;
  logic [7:0]       do_q, do_d;
  irq_state_e       state_q, state_d;

  logic             wr_en, rd_en, w1c, vec_rd, eoi_wr;
  logic [N_SRC-1:0] mode_eff, w1c_vec, ack_vec;
  logic [N_SRC-1:0] isr_low, isr_below, eligible;
  logic [7:0]       vec_word;
  logic             ack;
  cand_t            cand;

  assign wr_en  = cs & ~rw;
  assign rd_en  = cs & rw;
  assign w1c    = wr_en && (AD == REG_PEND);
  assign vec_rd = rd_en && (AD == REG_VECTOR);
  assign eoi_wr = wr_en && (AD == REG_EOI);

  assign mode_eff = mode_q | NMI_BIT;
  assign w1c_vec  = w1c ? DI : '0;

  // Only sources strictly above the highest-priority in-service one may nest.
  assign isr_low   = isr_q & (~isr_q + 8'd1);
  assign isr_below = isr_low - 8'd1;
  assign eligible  = pend_q & mask_q & ~isr_q & isr_below & CFG_BITS;
  assign cand      = lowest_set(eligible);

  assign ack     = vec_rd & cand.found;
  assign ack_vec = ack ? (8'd1 << cand.idx) : '0;

  always_comb begin
    vec_word                = '0;
    vec_word[VEC_VALID_BIT] = 1'b1;
    vec_word[2:0]           = cand.idx;
  end

  always_comb begin
    pend_d = (mode_eff & ((pend_q & ~w1c_vec & ~ack_vec) | sync_rise))
           | (~mode_eff & sync_lvl);
    mask_d = (wr_en && (AD == REG_MASK)) ? (DI & CFG_BITS) : mask_q;
    mode_d = (wr_en && (AD == REG_MODE)) ? (DI & CFG_BITS) : mode_q;
    isr_d  = isr_q;
    if (ack) begin
      isr_d = isr_q | ack_vec;
    end else if (eoi_wr) begin
      isr_d = isr_q & (isr_q - 8'd1);
    end
  end

  always_comb begin
    do_d = do_q;
    if (rd_en) begin
      case (AD)
        REG_PEND:   do_d = pend_q;
        REG_MASK:   do_d = mask_q;
        REG_MODE:   do_d = mode_q;
        REG_VECTOR: do_d = cand.found ? vec_word : 8'h00;
        REG_ISR:    do_d = isr_q;
        default:    do_d = 8'h00;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (cand.found && !vec_rd) state_d = ST_ASSERT;
      ST_ASSERT: if (vec_rd || !cand.found) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q  <= '0;
      mask_q  <= '0;
      mode_q  <= '0;
      isr_q   <= '0;
      do_q    <= '0;
      state_q <= ST_IDLE;
    end else begin
      pend_q  <= pend_d;
      mask_q  <= mask_d;
      mode_q  <= mode_d;
      isr_q   <= isr_d;
      do_q    <= do_d;
      state_q <= state_d;
    end
  end

  assign DO          = do_q;
  assign irq         = (state_q == ST_ASSERT);
  assign fsm_state_o = state_q;

`ifdef IRQ_CTRL_NMI_EN
  assign nmi = pend_q[0];
`else
  assign nmi = 1'b0;
`endif

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: directed scenarios followed by randomized
// register traffic compared against a register-level reference model.
module tb_irq_ctrl;
  import irq_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] AD;
  logic [7:0] DI;
  logic [7:0] DO;
  logic       rw;
  logic       cs;
  logic [7:0] src;
  logic       irq;
  logic       nmi;
  irq_state_e fsm_state;

`ifdef IRQ_CTRL_NMI_EN
  localparam bit NMI = 1'b1;
`else
  localparam bit NMI = 1'b0;
`endif

  irq_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .AD          (AD),
    .DI          (DI),
    .DO          (DO),
    .rw          (rw),
    .cs          (cs),
    .src         (src),
    .irq         (irq),
    .nmi         (nmi),
    .fsm_state_o (fsm_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks (inputs change on the falling edge) ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [7:0] d);
    AD = a; DI = d; rw = 1'b0; cs = 1'b1;
    tick();
    cs = 1'b0; rw = 1'b1;
    idle(2);
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [7:0] d);
    AD = a; rw = 1'b1; cs = 1'b1;
    tick();
    cs = 1'b0;
    d = DO;
  endtask

  // ---------------- reference model ----------------
  logic [7:0] m_pend, m_mask, m_mode, m_isr, m_src;

  function automatic logic [7:0] cfg_bits();
    return NMI ? 8'hFE : 8'hFF;
  endfunction

  function automatic logic [7:0] m_mode_eff();
    return NMI ? (m_mode | 8'h01) : m_mode;
  endfunction

  // Edge sources keep a latched flag; level sources simply show the input.
  function automatic logic [7:0] m_pend_view();
    logic [7:0] me;
    me = m_mode_eff();
    return (m_pend & me) | (m_src & ~me);
  endfunction

  function automatic int m_candidate();
    int lo;
    logic [7:0] p;
    lo = 8;
    for (int j = 7; j >= 0; j--) if (m_isr[j]) lo = j;
    p = m_pend_view();
    for (int i = 0; i < 8; i++) begin
      if (i >= lo) break;
      if (NMI && i == 0) continue;
      if (p[i] && m_mask[i] && !m_isr[i]) return i;
    end
    return -1;
  endfunction

  // ---------------- stimulus ----------------
  logic [7:0] rd;
  logic [7:0] d;
  logic [7:0] nsrc, newmode, old_eff, new_eff;
  logic [3:0] a;
  int         op, c;
  logic [3:0] rd_regs[5];

  initial begin
    rd_regs[0] = REG_PEND; rd_regs[1] = REG_MASK; rd_regs[2] = REG_MODE;
    rd_regs[3] = REG_VECTOR; rd_regs[4] = REG_ISR;
    rst = 1'b1; cs = 1'b0; rw = 1'b1; AD = '0; DI = '0; src = '0;
    idle(3);
    check8("reset_do", DO, 8'h00);
    check8("reset_irq", {7'b0, irq}, 8'h00);
    check8("reset_nmi", {7'b0, nmi}, 8'h00);
    rst = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      bus_read(rd_regs[i], rd);
      check8($sformatf("reset_reg%0h", rd_regs[i]), rd, 8'h00);
    end

    // Edge source 2: latency, vector, acknowledge.
    bus_write(REG_MASK, 8'h04);
    bus_write(REG_MODE, 8'h04);
    src[2] = 1'b1;
    idle(3);
    check8("lat_3clk_irq", {7'b0, irq}, 8'h00);
    tick();
    check8("lat_4clk_irq", {7'b0, irq}, 8'h01);
    bus_read(REG_VECTOR, rd);
    check8("vec_src2", rd, 8'h82);
    check8("irq_fall", {7'b0, irq}, 8'h00);
    bus_read(REG_PEND, rd);
    check8("pend_after_ack", rd, 8'h00);
    bus_read(REG_ISR, rd);
    check8("isr_after_ack", rd, 8'h04);

    // Level source 5 blocked by in-service source 2 until EOI.
    bus_write(REG_MASK, 8'h24);
    src[5] = 1'b1;
    idle(6);
    check8("nest_block_irq", {7'b0, irq}, 8'h00);
    bus_read(REG_PEND, rd);
    check8("level_pend", rd, 8'h20);
    bus_write(REG_EOI, 8'h5A);
    check8("eoi_irq", {7'b0, irq}, 8'h01);
    bus_read(REG_VECTOR, rd);
    check8("vec_src5", rd, 8'h85);
    bus_read(REG_ISR, rd);
    check8("isr_src5", rd, 8'h20);

    // Higher-priority edge source 1 nests over in-service source 5.
    src = 8'h00;
    idle(4);
    bus_write(REG_MASK, 8'h22);
    bus_write(REG_MODE, 8'h02);
    src[1] = 1'b1;
    idle(5);
    check8("nest_irq", {7'b0, irq}, 8'h01);
    bus_read(REG_VECTOR, rd);
    check8("vec_src1", rd, 8'h81);
    bus_read(REG_ISR, rd);
    check8("isr_nested", rd, 8'h22);
    bus_write(REG_EOI, 8'h00);
    bus_read(REG_ISR, rd);
    check8("isr_first_eoi", rd, 8'h20);

    // Vector read with nothing eligible.
    bus_read(REG_VECTOR, rd);
    check8("vec_empty", rd, 8'h00);
    bus_read(REG_ISR, rd);
    check8("isr_unchanged", rd, 8'h20);
    idle(2);
    check8("irq_empty", {7'b0, irq}, 8'h00);
    bus_write(REG_EOI, 8'h00);
    bus_read(REG_ISR, rd);
    check8("isr_second_eoi", rd, 8'h00);

    // Set of PEND[3] wins over a W1C landing in the same cycle.
    src = 8'h00;
    idle(4);
    bus_write(REG_MODE, 8'h08);
    bus_write(REG_MASK, 8'h00);
    bus_read(REG_PEND, rd);
    check8("pend_pre_race", rd, 8'h00);
    src[3] = 1'b1;
    idle(2);
    AD = REG_PEND; DI = 8'h08; rw = 1'b0; cs = 1'b1;
    tick();
    cs = 1'b0; rw = 1'b1;
    tick();
    bus_read(REG_PEND, rd);
    check8("pend_set_wins", rd, 8'h08);
    bus_write(REG_PEND, 8'h08);
    bus_read(REG_PEND, rd);
    check8("pend_w1c", rd, 8'h00);

    // Unused address range.
    bus_write(REG_MASK, 8'h5A);
    bus_write(4'h7, 8'hFF);
    bus_write(4'hC, 8'hA5);
    bus_read(4'h7, rd);
    check8("read_7", rd, 8'h00);
    bus_read(4'hF, rd);
    check8("read_F", rd, 8'h00);
    bus_read(REG_MASK, rd);
    check8("mask_kept", rd, 8'h5A);
    bus_write(REG_MASK, 8'h00);

    src = 8'h00;
    idle(4);
`ifdef IRQ_CTRL_NMI_EN
    src[0] = 1'b1;
    idle(5);
    check8("nmi_set", {7'b0, nmi}, 8'h01);
    check8("nmi_no_irq", {7'b0, irq}, 8'h00);
    bus_write(REG_PEND, 8'h01);
    check8("nmi_clear", {7'b0, nmi}, 8'h00);
    bus_write(REG_MASK, 8'hFF);
    bus_read(REG_MASK, rd);
    check8("nmi_mask_bit0", rd, 8'hFE);
    bus_write(REG_MODE, 8'hFF);
    bus_read(REG_MODE, rd);
    check8("nmi_mode_bit0", rd, 8'hFE);
    bus_write(REG_MASK, 8'h00);
    bus_write(REG_MODE, 8'h00);
`else
    bus_write(REG_MASK, 8'h01);
    bus_write(REG_MODE, 8'h01);
    src[0] = 1'b1;
    idle(5);
    check8("src0_irq", {7'b0, irq}, 8'h01);
    check8("src0_nmi", {7'b0, nmi}, 8'h00);
    bus_read(REG_VECTOR, rd);
    check8("vec_src0", rd, 8'h80);
    bus_write(REG_EOI, 8'h00);
`endif
    src = 8'h00;
    idle(4);

    // Reset during service discards in-service state.
    bus_write(REG_MASK, 8'h10);
    bus_write(REG_MODE, 8'h10);
    src[4] = 1'b1;
    idle(5);
    bus_read(REG_VECTOR, rd);
    check8("vec_src4", rd, 8'h84);
    bus_read(REG_ISR, rd);
    check8("isr_src4", rd, 8'h10);
    src = 8'h00;
    idle(4);
    rst = 1'b1;
    tick();
    check8("midrst_do", DO, 8'h00);
    check8("midrst_irq", {7'b0, irq}, 8'h00);
    rst = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      bus_read(rd_regs[i], rd);
      check8($sformatf("midrst_reg%0h", rd_regs[i]), rd, 8'h00);
    end

    // Randomized traffic against the reference model.
    m_pend = '0; m_mask = '0; m_mode = '0; m_isr = '0; m_src = '0;
    for (int it = 0; it < 80; it++) begin
      op = $urandom_range(0, 6);
      d  = 8'($urandom);
      case (op)
        0: begin
          nsrc = 8'($urandom);
          src = nsrc;
          idle(5);
          for (int i = 0; i < 8; i++)
            if (m_mode_eff()[i] && !m_src[i] && nsrc[i]) m_pend[i] = 1'b1;
          m_src = nsrc;
        end
        1: begin
          bus_write(REG_MASK, d);
          m_mask = d & cfg_bits();
        end
        2: begin
          bus_write(REG_MODE, d);
          old_eff = m_mode_eff();
          newmode = d & cfg_bits();
          new_eff = NMI ? (newmode | 8'h01) : newmode;
          for (int i = 0; i < 8; i++)
            if (new_eff[i] && !old_eff[i]) m_pend[i] = m_src[i];
          m_mode = newmode;
        end
        3: begin
          bus_write(REG_PEND, d);
          m_pend = m_pend & ~(d & m_mode_eff());
        end
        4: begin
          c = m_candidate();
          if (c < 0) begin
            exp_q.push_back(8'h00);
          end else begin
            exp_q.push_back(8'h80 | 8'(c));
            m_isr[c] = 1'b1;
            if (m_mode_eff()[c]) m_pend[c] = 1'b0;
          end
          bus_read(REG_VECTOR, rd);
          check8($sformatf("rnd%0d_vector", it), rd, exp_q.pop_front());
          idle(2);
        end
        5: begin
          bus_write(REG_EOI, d);
          for (int i = 0; i < 8; i++)
            if (m_isr[i]) begin
              m_isr[i] = 1'b0;
              break;
            end
        end
        default: begin
          a = 4'($urandom_range(0, 15));
          if (a == REG_VECTOR) a = 4'hB;
          case (a)
            REG_PEND: exp_q.push_back(m_pend_view());
            REG_MASK: exp_q.push_back(m_mask);
            REG_MODE: exp_q.push_back(m_mode);
            REG_ISR:  exp_q.push_back(m_isr);
            default:  exp_q.push_back(8'h00);
          endcase
          bus_read(a, rd);
          check8($sformatf("rnd%0d_reg%0h", it, a), rd, exp_q.pop_front());
          idle(2);
        end
      endcase
      check8($sformatf("rnd%0d_irq", it), {7'b0, irq}, (m_candidate() >= 0) ? 8'h01 : 8'h00);
      check8($sformatf("rnd%0d_nmi", it), {7'b0, nmi}, NMI ? {7'b0, m_pend_view()[0]} : 8'h00);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/irq_ctrl.md
IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: system bus clock; all state is clocked on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port AD, input, 4 bits: register address.
REQ-004 SHALL have port DI, input, 8 bits: write data.
REQ-005 SHALL have port DO, output reg, 8 bits: read data.
REQ-006 SHALL have port rw, input, 1 bit: 1 selects read, 0 selects write.
REQ-007 SHALL have port cs, input, 1 bit: chip select; an access occurs only while cs=1.
REQ-008 SHALL have port src, input, 8 bits: asynchronous interrupt sources; bit 0 has the highest priority.
REQ-009 SHALL have port irq, output, 1 bit: registered, active-high CPU interrupt request.
REQ-010 SHALL have port nmi, output, 1 bit: registered, active-high non-maskable request.

Function
REQ-011 SHALL pass each src bit through a 2-flop synchronizer, followed by a delay flop for rising-edge detection.
REQ-012 SHALL provide these registers: $0 R PEND / W write-1-to-clear; $1 RW MASK (1=enabled); $2 RW MODE (1=edge, 0=level); $3 R VECTOR; $4 W EOI (data ignored); $5 R ISR (in-service).
REQ-013 SHALL, for an edge source, latch the PEND bit on a synchronized rising edge and clear it only by W1C or by a VECTOR acknowledge.
REQ-014 SHALL, for a level source, make the PEND bit equal the synchronized level; W1C and acknowledge SHALL have no effect on it.
REQ-015 SHALL give precedence to a PEND set over a W1C clear of the same bit in the same cycle.
REQ-016 SHALL define the candidate as the lowest index i with PEND[i]&MASK[i]&~ISR[i], where i is lower than the lowest set ISR bit (nesting by priority only).
REQ-017 SHALL implement a 2-state FSM: IDLE (irq=0) -> ASSERT when a candidate exists; ASSERT (irq=1) -> IDLE on a VECTOR read, or when no candidate remains (for example after a MASK/W1C write).
REQ-018 SHALL, on a VECTOR read, return {1,0000,idx[2:0]} of the candidate in that cycle, set ISR[idx], and clear PEND[idx] if idx is an edge source.
REQ-019 SHALL, on a VECTOR read with no candidate, return 8'h00 and change no state.
REQ-020 SHALL, on an EOI write, clear the lowest set ISR bit; an EOI with ISR=0 SHALL be a no-op.
REQ-021 SHALL register DO, valid on the clock edge after the read cycle; DO holds its value when no read occurs.
REQ-022 SHALL give 4-clk latency from a src rising edge to irq=1 (2 sync flops, PEND, FSM).
REQ-023 SHALL treat accesses to $6-$F as follows: reads return 8'h00, writes are ignored.

Reset
REQ-024 SHALL, while rst=1, asynchronously set PEND, MASK, MODE, ISR, DO and the synchronizer flops to 0, the FSM to IDLE, and irq=0, nmi=0.
REQ-025 SHALL, when rst asserts mid-service, discard all in-service state; no EOI is required afterwards.

Configuration
REQ-026 SHALL, with IRQ_CTRL_NMI_EN defined, treat src[0] as always edge and unmaskable and exclude it from the candidate/VECTOR logic; nmi = PEND[0], cleared by W1C of $0 bit 0; MASK[0], MODE[0] and ISR[0] SHALL read as 0.
REQ-027 SHALL, without IRQ_CTRL_NMI_EN, tie nmi to 0 and treat src[0] as an ordinary source.

Structure
REQ-028 SHALL take the register offsets, the source count (8), the vector valid-bit position and the FSM state encoding from the shared package irq_ctrl_pkg.
REQ-029 SHALL instantiate the sub-module irq_sync_edge once per source; it provides synchronizer, level output and rising-edge pulse.

Verification
REQ-030 SHALL verify: MASK=$04, MODE=$04, src[2] rising edge -> irq=1 4 clks later; VECTOR read returns $82; PEND[2]=0, ISR=$04; irq falls the following clk.
REQ-031 SHALL verify: ISR=$04 with src[5] level high and MASK=$24 -> irq stays 0; after EOI, irq=1 and VECTOR returns $85.
REQ-032 SHALL verify: ISR=$20 with an src[1] edge and MASK=$22, MODE=$02 -> irq=1 (nesting), VECTOR=$81, ISR=$22; first EOI leaves ISR=$20.
REQ-033 SHALL verify: a W1C of $0 with $08 in the same cycle as a src[3] synchronized edge -> PEND[3] remains 1.
REQ-034 SHALL verify: VECTOR read with nothing pending -> DO=$00 and ISR unchanged; rst pulsed while ISR=$10 -> all registers read $00.
REQ-035 SHALL verify: with IRQ_CTRL_NMI_EN and MASK=$00, a src[0] edge -> nmi=1 and irq=0; W1C of $01 -> nmi=0.
